// File: rtl/ppm16_rx_buffer_if.sv
// Handshake bundle between the PPM16 demodulator/consumer side and the rx byte buffer.
// master drives symbols and read requests; slave (the buffer) returns data and status.
interface ppm16_rx_buffer_if #(
    parameter int ADDR_BITS = 4
);
    logic                 packet_detected;
    logic                 din_valid;
    logic [3:0]           din;
    logic                 rd_en;
    logic                 clear_overflow;
    logic [7:0]           dout;
    logic                 dout_valid;
    logic                 empty;
    logic                 full;
    logic [ADDR_BITS:0]   count;
    logic                 overflow;
    logic                 nibble_pending;

    modport master (
        output packet_detected, din_valid, din, rd_en, clear_overflow,
        input  dout, dout_valid, empty, full, count, overflow, nibble_pending
    );

    modport slave (
        input  packet_detected, din_valid, din, rd_en, clear_overflow,
        output dout, dout_valid, empty, full, count, overflow, nibble_pending
    );
endinterface

// File: rtl/ppm16_rx_buffer.sv
// Packs PPM16 nibbles into bytes and queues them in a circular buffer; reads return data 1 cycle after rd_en.
// No backpressure to the demodulator: a byte arriving while full (without a same-cycle read) is dropped and flagged.
module ppm16_rx_buffer #(
    parameter int DEPTH     = 16,
    parameter int ADDR_BITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    ppm16_rx_buffer_if.slave   bus
);
    localparam logic [ADDR_BITS:0]   DEPTH_C = (ADDR_BITS+1)'(DEPTH);
    localparam logic [ADDR_BITS:0]   CNT_ONE = (ADDR_BITS+1)'(1);
    localparam logic [ADDR_BITS-1:0] PTR_ONE = (ADDR_BITS)'(1);

    logic [7:0]           mem [DEPTH];

    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS:0]   count_q, count_d;
    logic                 pend_q, pend_d;
    logic [3:0]           held_q, held_d;
    logic                 ovf_q, ovf_d;
    logic [7:0]           dout_q, dout_d;
    logic                 dout_vld_q, dout_vld_d;

    logic                 push;
    logic [7:0]           push_dat;
    logic                 push_acc;
    logic                 rd_acc;
    logic                 full;

    assign full = (count_q == DEPTH_C);

    always_comb begin
        push     = 1'b0;
        push_dat = 8'h00;
        pend_d   = pend_q;
        held_d   = held_q;

        // A packet start flushes a half byte zero-padded; a new symbol in the same cycle starts the next byte.
        if (bus.packet_detected && pend_q) begin
            push     = 1'b1;
            push_dat = {4'h0, held_q};
        end else if (bus.din_valid && pend_q) begin
            push     = 1'b1;
            push_dat = {bus.din, held_q};
        end

        if (bus.din_valid) begin
            if (pend_q && !bus.packet_detected) begin
                pend_d = 1'b0;
            end else begin
                pend_d = 1'b1;
                held_d = bus.din;
            end
        end else if (bus.packet_detected) begin
            pend_d = 1'b0;
        end

        rd_acc   = bus.rd_en && (count_q != '0);
        push_acc = push && (!full || rd_acc);
        ovf_d    = (push && !push_acc) || (ovf_q && !bus.clear_overflow);

        wr_ptr_d = push_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = rd_acc   ? rd_ptr_q + PTR_ONE : rd_ptr_q;

        count_d = count_q;
        if (push_acc && !rd_acc) begin
            count_d = count_q + CNT_ONE;
        end else if (rd_acc && !push_acc) begin
            count_d = count_q - CNT_ONE;
        end

        dout_vld_d = rd_acc;
        dout_d     = rd_acc ? mem[rd_ptr_q] : dout_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pend_q     <= 1'b0;
            held_q     <= 4'h0;
            ovf_q      <= 1'b0;
            dout_q     <= 8'h00;
            dout_vld_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pend_q     <= pend_d;
            held_q     <= held_d;
            ovf_q      <= ovf_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
        end
    end

    // When full with a same-cycle read, wr_ptr == rd_ptr: the read above sees the old entry before this overwrite.
    always_ff @(posedge clk) begin
        if (push_acc && !reset) begin
            mem[wr_ptr_q] <= push_dat;
        end
    end

    assign bus.dout           = dout_q;
    assign bus.dout_valid     = dout_vld_q;
    assign bus.empty          = (count_q == '0);
    assign bus.full           = full;
    assign bus.count          = count_q;
    assign bus.overflow       = ovf_q;
    assign bus.nibble_pending = pend_q;
endmodule

// File: tb/tb_ppm16_rx_buffer.sv
// Randomized and directed bench for ppm16_rx_buffer against a queue-based byte model.
module tb_ppm16_rx_buffer;
    localparam int DEPTH = 16;
    localparam int AB    = 4;

    logic clk = 1'b0;
    logic reset;

    ppm16_rx_buffer_if #(.ADDR_BITS(AB)) bus ();
    ppm16_rx_buffer #(.DEPTH(DEPTH), .ADDR_BITS(AB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    byte unsigned q[$];
    logic         m_pend;
    logic [3:0]   m_held;
    logic         m_ovf;
    logic         m_dv;
    logic [7:0]   m_dout;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check_val("count", 32'(bus.count), 32'(q.size()));
        check_val("flags", {28'h0, bus.empty, bus.full, bus.overflow, bus.nibble_pending},
                  {28'h0, q.size() == 0, q.size() == DEPTH, m_ovf, m_pend});
        check_val("dout", {23'h0, bus.dout_valid, bus.dout}, {23'h0, m_dv, m_dout});
    endtask

    task automatic drive(input logic pd, input logic dv, input logic [3:0] d,
                         input logic rd, input logic clr);
        bus.packet_detected = pd;
        bus.din_valid       = dv;
        bus.din             = d;
        bus.rd_en           = rd;
        bus.clear_overflow  = clr;
    endtask

    // One clock of stimulus; model advances from the spec's byte-level rules.
    task automatic cycle(input logic pd, input logic dv, input logic [3:0] d,
                         input logic rd, input logic clr);
        logic       rd_ok;
        logic       push;
        logic       drop;
        logic [7:0] pb;
        drive(pd, dv, d, rd, clr);
        rd_ok = rd && (q.size() != 0);
        push  = 1'b0;
        pb    = 8'h00;
        if (m_pend && (pd || dv)) begin
            push = 1'b1;
            pb   = pd ? {4'h0, m_held} : {d, m_held};
        end
        @(posedge clk);
        #1;
        m_dv = rd_ok;
        if (rd_ok) m_dout = q.pop_front();
        drop = 1'b0;
        if (push) begin
            if (q.size() < DEPTH) q.push_back(pb);
            else drop = 1'b1;
        end
        m_ovf = drop || (m_ovf && !clr);
        if (dv) begin
            if (m_pend && !pd) begin
                m_pend = 1'b0;
            end else begin
                m_pend = 1'b1;
                m_held = d;
            end
        end else if (pd) begin
            m_pend = 1'b0;
        end
        drive(0, 0, 4'h0, 0, 0);
        check_all();
    endtask

    task automatic do_reset(input logic noisy);
        reset = 1'b1;
        if (noisy) drive(1'b1, 1'b1, 4'hF, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(0, 0, 4'h0, 0, 0);
        q.delete();
        m_pend = 1'b0;
        m_held = 4'h0;
        m_ovf  = 1'b0;
        m_dv   = 1'b0;
        m_dout = 8'h00;
        check_all();
        check_val("rst_empty", 32'(bus.empty), 32'd1);
        check_val("rst_full", 32'(bus.full), 32'd0);
    endtask

    task automatic push_byte(input logic [7:0] b, input logic rd);
        cycle(0, 1, b[3:0], rd, 0);
        cycle(0, 1, b[7:4], rd, 0);
    endtask

    initial begin
        logic [7:0] exp_bytes [17];
        reset = 1'b1;
        drive(0, 0, 4'h0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        do_reset(1'b0);

        // Two nibbles form one byte, read back one cycle later.
        cycle(0, 1, 4'h3, 0, 0);
        check_val("r35_pend", 32'(bus.nibble_pending), 32'd1);
        cycle(0, 1, 4'hA, 0, 0);
        check_val("r35_count", 32'(bus.count), 32'd1);
        cycle(0, 0, 4'h0, 1, 0);
        check_val("r35_dout", {23'h0, bus.dout_valid, bus.dout}, {23'h0, 1'b1, 8'hA3});
        check_val("r35_empty", 32'(bus.empty), 32'd1);
        cycle(0, 0, 4'h0, 1, 0);
        check_val("empty_rd_novld", 32'(bus.dout_valid), 32'd0);
        check_val("empty_rd_hold", 32'(bus.dout), 32'hA3);

        // Zero-padded flush on packet start.
        cycle(0, 1, 4'h5, 0, 0);
        cycle(1, 0, 4'h0, 0, 0);
        check_val("r36_count", 32'(bus.count), 32'd1);
        check_val("r36_pend", 32'(bus.nibble_pending), 32'd0);
        cycle(1, 0, 4'h0, 1, 0);
        check_val("r36_dout", 32'(bus.dout), 32'h05);
        check_val("r21_noflush", 32'(bus.count), 32'd0);

        // Flush and capture in the same cycle.
        cycle(0, 1, 4'h2, 0, 0);
        cycle(1, 1, 4'h7, 0, 0);
        check_val("r37_count", 32'(bus.count), 32'd1);
        check_val("r37_pend", 32'(bus.nibble_pending), 32'd1);
        cycle(0, 1, 4'h1, 0, 0);
        cycle(0, 0, 4'h0, 1, 0);
        check_val("r37_b0", 32'(bus.dout), 32'h02);
        cycle(0, 0, 4'h0, 1, 0);
        check_val("r37_b1", 32'(bus.dout), 32'h17);

        // Overflow on 17th byte, in-order drain, clear.
        do_reset(1'b0);
        for (int i = 0; i < 17; i++) begin
            exp_bytes[i] = 8'($urandom_range(0, 255));
            push_byte(exp_bytes[i], 1'b0);
        end
        check_val("r38_full", 32'(bus.full), 32'd1);
        check_val("r38_count", 32'(bus.count), 32'd16);
        check_val("r38_ovf", 32'(bus.overflow), 32'd1);
        for (int i = 0; i < 16; i++) begin
            cycle(0, 0, 4'h0, 1, 0);
            check_val("r38_order", 32'(bus.dout), 32'(exp_bytes[i]));
        end
        check_val("r38_ovf_sticky", 32'(bus.overflow), 32'd1);
        cycle(0, 0, 4'h0, 0, 1);
        check_val("r38_clr", 32'(bus.overflow), 32'd0);

        // Streaming while full: flush+capture pushes every cycle alongside a read.
        do_reset(1'b0);
        for (int i = 0; i < 16; i++) push_byte(8'($urandom_range(0, 255)), 1'b0);
        cycle(0, 1, 4'($urandom_range(0, 15)), 0, 0);
        for (int i = 0; i < 48; i++) cycle(1, 1, 4'($urandom_range(0, 15)), 1, 0);
        check_val("r39_count", 32'(bus.count), 32'd16);
        check_val("r39_ovf", 32'(bus.overflow), 32'd0);

        // Reset discards pending nibble and stored bytes.
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) push_byte(8'($urandom_range(0, 255)), 1'b0);
        cycle(0, 1, 4'h9, 0, 0);
        check_val("r40_pre", 32'(bus.count), 32'd3);
        do_reset(1'b1);
        check_val("r40_all", {19'h0, bus.count, bus.dout, bus.dout_valid, bus.overflow, bus.nibble_pending},
                  32'h0);
        cycle(0, 0, 4'h0, 1, 0);
        check_val("r40_novld", 32'(bus.dout_valid), 32'd0);

        // Random traffic: a filling phase followed by a draining phase.
        for (int i = 0; i < 600; i++) begin
            logic pd, dv, rd, clr;
            pd  = ($urandom_range(0, 7) == 0);
            dv  = ($urandom_range(0, 1) == 1);
            rd  = (i < 300) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 15) == 0);
            cycle(pd, dv, 4'($urandom_range(0, 15)), rd, clr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
